// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Brief    : Multi-cycle multiply/divide unit with HI/LO registers. A started
//            mult/multu/div/divu holds busy for a fixed number of cycles, then
//            commits its result to HI/LO. mthi/mtlo write HI/LO directly while
//            idle; mfhi/mflo read them back combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] read1,
    input  logic [31:0] read2,
    input  logic [3:0]  mdu_op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_data
);

    localparam logic [3:0] c_op_mult  = 4'd1;
    localparam logic [3:0] c_op_multu = 4'd2;
    localparam logic [3:0] c_op_div   = 4'd3;
    localparam logic [3:0] c_op_divu  = 4'd4;
    localparam logic [3:0] c_op_mthi  = 4'd5;
    localparam logic [3:0] c_op_mtlo  = 4'd6;
    localparam logic [3:0] c_op_mfhi  = 4'd7;
    localparam logic [3:0] c_op_mflo  = 4'd8;

    localparam int c_max_cycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles + 1);
    localparam logic [c_cnt_w-1:0] c_mult_cnt = c_cnt_w'(MULT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_div_cnt  = c_cnt_w'(DIV_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [c_cnt_w-1:0]   r_count;
    logic [31:0]          r_a;
    logic [31:0]          r_b;
    logic [3:0]           r_op;
    logic [31:0]          r_hi;
    logic [31:0]          r_lo;

    logic                 w_is_md_op;
    logic                 w_accept;
    logic                 w_done;
    logic [63:0]          w_prod_s;
    logic [63:0]          w_prod_u;
    logic [31:0]          w_mag_a;
    logic [31:0]          w_mag_b;
    logic [31:0]          w_mag_q;
    logic [31:0]          w_mag_r;
    logic                 w_res_wr;
    logic [31:0]          w_res_hi;
    logic [31:0]          w_res_lo;

    assign w_is_md_op = (mdu_op >= c_op_mult) && (mdu_op <= c_op_divu);
    assign w_accept   = (r_state == ST_IDLE) && start && w_is_md_op;
    assign w_done     = (r_state == ST_RUN) && (r_count == c_cnt_one);
    assign busy       = (r_state == ST_RUN);
    assign hi         = r_hi;
    assign lo         = r_lo;

    // State register: reset drops straight back to idle, aborting any op
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: leave idle on an accepted start, return when the count expires
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_RUN;
            ST_RUN:  if (w_done)   w_next = ST_IDLE;
        endcase
    end

    // Result datapath from latched operands; signed divide is done on magnitudes
    // so the INT_MIN / -1 case wraps to INT_MIN instead of overflowing
    always_comb begin
        w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
        w_prod_u = {32'd0, r_a} * {32'd0, r_b};
        w_mag_a  = r_a[31] ? (32'd0 - r_a) : r_a;
        w_mag_b  = r_b[31] ? (32'd0 - r_b) : r_b;
        w_mag_q  = w_mag_a / w_mag_b;
        w_mag_r  = w_mag_a % w_mag_b;
        w_res_wr = 1'b0;
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        case (r_op)
            c_op_mult: begin
                w_res_wr = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_s;
            end
            c_op_multu: begin
                w_res_wr = 1'b1;
                {w_res_hi, w_res_lo} = w_prod_u;
            end
            c_op_div: begin
                if (r_b != 32'd0) begin
                    w_res_wr = 1'b1;
                    w_res_lo = (r_a[31] ^ r_b[31]) ? (32'd0 - w_mag_q) : w_mag_q;
                    w_res_hi = r_a[31] ? (32'd0 - w_mag_r) : w_mag_r;
                end
            end
            c_op_divu: begin
                if (r_b != 32'd0) begin
                    w_res_wr = 1'b1;
                    w_res_lo = r_a / r_b;
                    w_res_hi = r_a % r_b;
                end
            end
            default: begin
                w_res_wr = 1'b0;
            end
        endcase
    end

    // Operand latch, cycle counter, and HI/LO commit (result or mthi/mtlo)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_op    <= 4'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else if (w_accept) begin
            r_a     <= read1;
            r_b     <= read2;
            r_op    <= mdu_op;
            r_count <= ((mdu_op == c_op_mult) || (mdu_op == c_op_multu)) ? c_mult_cnt : c_div_cnt;
        end else if (r_state == ST_RUN) begin
            r_count <= r_count - c_cnt_one;
            if (w_done && w_res_wr) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end
        end else begin
            if (mdu_op == c_op_mthi) begin
                r_hi <= read1;
            end else if (mdu_op == c_op_mtlo) begin
                r_lo <= read1;
            end
        end
    end

    // Read port: committed HI/LO only, so a pending result is never visible early
    always_comb begin
        mdu_data = 32'd0;
        case (mdu_op)
            c_op_mfhi: mdu_data = r_hi;
            c_op_mflo: mdu_data = r_lo;
            default:   mdu_data = 32'd0;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, giving the busy duration in cycles of mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, giving the busy duration in cycles of div/divu.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 read1  input  32  operand A (rs value).
REQ-006 read2  input  32  operand B (rt value).
REQ-007 mdu_op  input  4  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo, 9-15 none.
REQ-008 start  input  1  one-cycle request to begin the op on mdu_op (codes 1-4 only).
REQ-009 busy  output  1  high while a mult/div is in flight.
REQ-010 hi  output  32  HI register.
REQ-011 lo  output  32  LO register.
REQ-012 mdu_data  output  32  read port: hi on mfhi, lo on mflo, else 0.

Function
REQ-013 SHALL be a two-state FSM: IDLE (busy=0) and RUN (busy=1), with a down-counter.
REQ-014 IDLE->RUN SHALL occur at an edge with start=1 and mdu_op in 1..4; the edge latches read1, read2, the op, and counter = MULT_CYCLES or DIV_CYCLES.
REQ-015 busy SHALL be 1 for exactly N cycles after the start edge (N = 5 mult, 10 div by default).
REQ-016 At the Nth edge after start, HI/LO SHALL be written and FSM SHALL return to IDLE on the same edge.
REQ-017 start SHALL be ignored while busy=1, and when mdu_op is not 1..4.
REQ-018 Results SHALL depend only on the latched operands; read1/read2 changes during RUN SHALL have no effect.
REQ-019 mult SHALL compute signed 32x32->64; multu SHALL compute unsigned 32x32->64; both give {hi,lo} = product.
REQ-020 div SHALL give lo = signed quotient truncated toward zero and hi = remainder with the sign of the dividend.
REQ-021 divu SHALL give unsigned lo = quotient and hi = remainder.
REQ-022 div/divu with read2=0 SHALL run full DIV_CYCLES and leave hi/lo unchanged.
REQ-023 div of 0x80000000 by 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-024 mthi/mtlo SHALL write read1 into hi/lo at any edge with busy=0, without needing start.
REQ-025 mthi/mtlo SHALL be ignored during RUN (pipeline stalls); they SHALL NOT cancel an in-flight op.
REQ-026 mdu_data SHALL be combinational from hi/lo and mdu_op, and SHALL reflect the committed registers (pre-result value while busy).
REQ-027 Back-to-back: start SHALL be accepted at the same edge busy falls only if busy was already 0 before that edge; it is accepted the following cycle.

Reset
REQ-028 reset=1 SHALL immediately force IDLE, busy=0, counter=0, hi=0, lo=0, and latched operands/op=0, independent of clk.
REQ-029 Reset asserted mid-RUN SHALL abort the op with no HI/LO write; the first accepted start after release SHALL behave normally.

Verification
REQ-030 mult read1=0xFFFFFFFF, read2=2, start 1 cycle -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
REQ-031 multu same operands -> after 5 cycles hi=0x00000001, lo=0xFFFFFFFE.
REQ-032 div read1=-7 (0xFFFFFFF9), read2=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/0 -> hi/lo unchanged after 10 cycles.
REQ-033 start held high with changed operands during RUN, plus mtlo during RUN -> single result from original operands; lo not overwritten by mtlo; busy exactly N cycles.
REQ-034 mthi read1=0x12345678 in IDLE, then mfhi -> hi and mdu_data = 0x12345678 next cycle; mdu_op=0 -> mdu_data=0.
REQ-035 reset pulse 3 cycles into a div -> busy=0, hi=lo=0 asynchronously, no later write; a new mult then completes in 5 cycles.
